// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store split engine.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ0,
      ST_WAIT0,
      ST_REQ1,
      ST_WAIT1,
      ST_RESP
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Byte-enable mask of a (1<<size)-byte access at byte offset off, spanning
   // two bus words: bits [nb-1:0] are beat 0, bits [2*nb-1:nb] are beat 1.
   function automatic logic [15:0] be_mask(input logic [1:0] size, input int off, input int nb);
      return 16'((((32'd1 << (32'd1 << size)) - 32'd1) << off) & ((32'd1 << (2 * nb)) - 32'd1));
   endfunction

endpackage

// File: rtl/lsu_split_engine_align.sv
// Combinational lane network: beat byte enables, lane-aligned store data,
// and load merge with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [$clog2(DATA_W/8)-1:0] off,
   input  logic [1:0]                  size,
   input  logic                        sgn,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [DATA_W-1:0]           rdata0,
   input  logic [DATA_W-1:0]           rdata1,
   output logic                        split,
   output logic [DATA_W/8-1:0]         be0,
   output logic [DATA_W/8-1:0]         be1,
   output logic [DATA_W-1:0]           wdata0,
   output logic [DATA_W-1:0]           wdata1,
   output logic [DATA_W-1:0]           ld_data
);
   localparam int NB = DATA_W / 8;
   localparam int MW = 2 * NB;

   logic [MW-1:0]       mask;
   logic [2*DATA_W-1:0] wide_w;
   logic [DATA_W-1:0]   raw;
   logic                sbit;
   int                  nbytes;
   int                  sh;

   // Place store data across two words, merge load words, then extend
   always_comb begin
      nbytes = 1 << size;
      sh     = 8 * int'(off);
      mask   = MW'(be_mask(size, int'(off), NB));
      split  = (int'(off) + nbytes) > NB;
      be0    = mask[NB-1:0];
      be1    = mask[MW-1:NB];
      wide_w = {{DATA_W{1'b0}}, wdata} << sh;
      wdata0 = wide_w[DATA_W-1:0];
      wdata1 = wide_w[2*DATA_W-1:DATA_W];
      raw    = DATA_W'({(split ? rdata1 : {DATA_W{1'b0}}), rdata0} >> sh);
      sbit   = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (i == nbytes - 1) sbit = sgn & raw[8*i+7];
      end
      ld_data = '0;
      for (int i = 0; i < NB; i++) begin
         ld_data[8*i +: 8] = (i < nbytes) ? raw[8*i +: 8] : {8{sbit}};
      end
   end

endmodule

// File: rtl/lsu_split_engine.sv
// Load/store engine between the pipeline and the data bus. One access at a
// time; bus-word-crossing accesses become two beats when LSU_MISALIGNED_EN is
// defined, otherwise they are rejected with resp_err_o.
module lsu_split_engine
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_we_i,
   input  logic                req_signed_i,
   output logic                resp_valid_o,
   output logic [DATA_W-1:0]   resp_rdata_o,
   output logic                resp_err_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
`ifdef LSU_MISALIGNED_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   lsu_state_t        state, state_nxt;
   logic [OFF_W-1:0]  off_q, a_off;
   logic [1:0]        size_q, a_size;
   logic              we_q, sgn_q;
   logic [DATA_W-1:0] rdata0_q, a_rdata0;
   logic [NB-1:0]     be1_q;
   logic [DATA_W-1:0] wdata1_q;
   logic              split, acc_err;
   logic [NB-1:0]     be0, be1;
   logic [DATA_W-1:0] wdata0, wdata1, ld_data;

   // The lane network sees the live request in IDLE and the latched access after
   always_comb begin
      a_off    = off_q;
      a_size   = size_q;
      a_rdata0 = rdata0_q;
      if (state == ST_IDLE) begin
         a_off  = req_addr_i[OFF_W-1:0];
         a_size = req_size_i;
      end
      if (state == ST_WAIT0) a_rdata0 = mem_rdata_i;
   end

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .off     (a_off),
      .size    (a_size),
      .sgn     (sgn_q),
      .wdata   (req_wdata_i),
      .rdata0  (a_rdata0),
      .rdata1  (mem_rdata_i),
      .split   (split),
      .be0     (be0),
      .be1     (be1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .ld_data (ld_data)
   );

   assign acc_err      = ((req_size_i == SZ_D) && (DATA_W == 32)) || (split && !MIS_EN);
   assign req_ready_o  = (state == ST_IDLE);
   assign mem_req_o    = (state == ST_REQ0) || (state == ST_REQ1);
   assign resp_valid_o = (state == ST_RESP);

   // Next-state sequencing of the one or two bus beats
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (req_valid_i) state_nxt = acc_err ? ST_RESP : ST_REQ0;
         ST_REQ0:  if (mem_gnt_i) state_nxt = ST_WAIT0;
         ST_WAIT0: if (mem_rvalid_i) state_nxt = (split && MIS_EN) ? ST_REQ1 : ST_RESP;
`ifdef LSU_MISALIGNED_EN
         ST_REQ1:  if (mem_gnt_i) state_nxt = ST_WAIT1;
         ST_WAIT1: if (mem_rvalid_i) state_nxt = ST_RESP;
`endif
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered bus/response outputs
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state        <= ST_IDLE;
         mem_addr_o   <= '0;
         mem_be_o     <= '0;
         mem_wdata_o  <= '0;
         mem_we_o     <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
      end else begin
         state        <= state_nxt;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         if (state == ST_IDLE && req_valid_i) begin
            if (acc_err) begin
               resp_err_o <= 1'b1;
            end else begin
               mem_addr_o  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               mem_be_o    <= be0;
               mem_wdata_o <= wdata0;
               mem_we_o    <= req_we_i;
            end
         end
         // Second beat: next bus word, wrapping at the top of the address space
         if (state == ST_WAIT0 && state_nxt == ST_REQ1) begin
            mem_addr_o  <= mem_addr_o + ADDR_W'(NB);
            mem_be_o    <= be1_q;
            mem_wdata_o <= wdata1_q;
         end
         if ((state == ST_WAIT0 || state == ST_WAIT1) && state_nxt == ST_RESP) begin
            resp_rdata_o <= we_q ? '0 : ld_data;
         end
      end
   end

   // Access attributes and beat-0 read data; data path, not reset
   always_ff @(posedge clk_i) begin
      if (state == ST_IDLE && req_valid_i) begin
         off_q    <= req_addr_i[OFF_W-1:0];
         size_q   <= req_size_i;
         we_q     <= req_we_i;
         sgn_q    <= req_signed_i;
         be1_q    <= be1;
         wdata1_q <= wdata1;
      end
      if (state == ST_WAIT0 && mem_rvalid_i) rdata0_q <= mem_rdata_i;
   end

endmodule

// File: tb/tb_lsu_split_engine.sv
// Directed bench for lsu_split_engine (DATA_W=32); expectations follow
// LSU_MISALIGNED_EN as seen by this compile.
`timescale 1ns/1ps
module tb_lsu_split_engine;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [1:0]  req_size_i;
   logic        req_we_i;
   logic        req_signed_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic [31:0] mem_addr_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   lsu_split_engine #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_size_i   (req_size_i),
      .req_we_i     (req_we_i),
      .req_signed_i (req_signed_i),
      .resp_valid_o (resp_valid_o),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_addr_o   (mem_addr_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // bus model state
   int          gnt_stall = 0;
   int          stall_cnt = 0;
   int          nbeats    = 0;
   bit          rv_pending = 1'b0;
   bit          unstable   = 1'b0;
   logic [31:0] bd0, bd1;
   logic [31:0] first_addr;
   logic [3:0]  first_be;
   logic [31:0] rec_addr  [4];
   logic [3:0]  rec_be    [4];
   logic [31:0] rec_wdata [4];
   logic        rec_we    [4];

   // Slave: grant after gnt_stall cycles, rvalid one cycle after grant
   initial begin : bus_model
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(negedge clk_i);
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (reset_i !== 1'b1) begin
            rv_pending = 1'b0;
            stall_cnt  = 0;
         end else if (rv_pending) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = (nbeats == 1) ? bd0 : bd1;
            rv_pending   = 1'b0;
         end else if (mem_req_o === 1'b1) begin
            if (stall_cnt == 0) begin
               first_addr = mem_addr_o;
               first_be   = mem_be_o;
            end else if (mem_addr_o !== first_addr || mem_be_o !== first_be) begin
               unstable = 1'b1;
            end
            if (stall_cnt < gnt_stall) begin
               stall_cnt++;
            end else begin
               mem_gnt_i = 1'b1;
               if (nbeats < 4) begin
                  rec_addr[nbeats[1:0]]  = mem_addr_o;
                  rec_be[nbeats[1:0]]    = mem_be_o;
                  rec_wdata[nbeats[1:0]] = mem_wdata_o;
                  rec_we[nbeats[1:0]]    = mem_we_o;
               end
               nbeats++;
               stall_cnt  = 0;
               rv_pending = 1'b1;
            end
         end
      end
   end

   // Issue one request and wait (bounded) for its response pulse
   task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz,
                         input logic we, input logic sg, output int lat, output logic [31:0] rd,
                         output logic er, output logic rdy0, output logic rv0, output logic rdy1);
      lat = -1;
      rd  = '0;
      er  = 1'b0;
      @(negedge clk_i);
      nbeats       = 0;
      rdy0         = req_ready_o;
      rv0          = resp_valid_o;
      req_valid_i  = 1'b1;
      req_addr_i   = addr;
      req_wdata_i  = wd;
      req_size_i   = sz;
      req_we_i     = we;
      req_signed_i = sg;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rdy1        = req_ready_o;
      for (int k = 1; k <= 40; k++) begin
         if (resp_valid_o === 1'b1) begin
            lat = k;
            rd  = resp_rdata_o;
            er  = resp_err_o;
            break;
         end
         @(negedge clk_i);
      end
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er, rdy0, rv0, rdy1;

   task automatic test_reset();
      reset_i      = 1'b0;
      req_valid_i  = 1'b0;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      req_size_i   = 2'd0;
      req_we_i     = 1'b0;
      req_signed_i = 1'b0;
      bd0 = '0;
      bd1 = '0;
      repeat (2) @(negedge clk_i);
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
      total++; if ({mem_req_o, resp_valid_o, resp_err_o, mem_we_o} !== 4'b0000) begin bad++;
         $display("FAIL reset_ctrl got=%b exp=0000", {mem_req_o, resp_valid_o, resp_err_o, mem_we_o}); end
      total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
      total++; if (mem_be_o !== 4'h0) begin bad++; $display("FAIL reset_be got=%h exp=0", mem_be_o); end
      total++; if (mem_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
      total++; if (resp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata_o); end
      reset_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_store_split();
      do_req(32'h1002, 32'hA1B2C3D4, 2'd2, 1'b1, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
`ifdef LSU_MISALIGNED_EN
      total++; if (lat !== 5) begin bad++; $display("FAIL st_split_lat got=%0d exp=5", lat); end
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL st_split_resp err=%b rd=%h exp err=0 rd=0", er, rd); end
      total++; if (nbeats !== 2) begin bad++; $display("FAIL st_split_beats got=%0d exp=2", nbeats); end
      total++; if (rec_addr[0] !== 32'h1000 || rec_be[0] !== 4'b1100 || rec_wdata[0] !== 32'hC3D40000 || rec_we[0] !== 1'b1) begin bad++;
         $display("FAIL st_split_b0 got addr=%h be=%b wd=%h we=%b exp 1000 1100 c3d40000 1", rec_addr[0], rec_be[0], rec_wdata[0], rec_we[0]); end
      total++; if (rec_addr[1] !== 32'h1004 || rec_be[1] !== 4'b0011 || rec_wdata[1] !== 32'h0000A1B2 || rec_we[1] !== 1'b1) begin bad++;
         $display("FAIL st_split_b1 got addr=%h be=%b wd=%h we=%b exp 1004 0011 0000a1b2 1", rec_addr[1], rec_be[1], rec_wdata[1], rec_we[1]); end
`else
      total++; if (lat !== 1 || er !== 1'b1) begin bad++; $display("FAIL st_split_err lat=%0d err=%b exp lat=1 err=1", lat, er); end
      total++; if (nbeats !== 0) begin bad++; $display("FAIL st_split_nobus got=%0d exp=0", nbeats); end
`endif
      total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL st_busy_ready got=%b exp=0", rdy1); end
   endtask

   task automatic test_signed_half_split();
      bd0 = 32'h11223344;
      bd1 = 32'h556677F8;
      do_req(32'h1003, 32'h0, 2'd1, 1'b0, 1'b1, lat, rd, er, rdy0, rv0, rdy1);
`ifdef LSU_MISALIGNED_EN
      total++; if (rd !== 32'hFFFFF811 || er !== 1'b0) begin bad++; $display("FAIL ld_half_split got rd=%h err=%b exp fffff811 0", rd, er); end
      total++; if (lat !== 5) begin bad++; $display("FAIL ld_half_lat got=%0d exp=5", lat); end
      total++; if (rec_be[0] !== 4'b1000 || rec_be[1] !== 4'b0001 || rec_we[0] !== 1'b0) begin bad++;
         $display("FAIL ld_half_be got be0=%b be1=%b we=%b exp 1000 0001 0", rec_be[0], rec_be[1], rec_we[0]); end
`else
      total++; if (lat !== 1 || er !== 1'b1 || nbeats !== 0) begin bad++;
         $display("FAIL ld_half_err got lat=%0d err=%b beats=%0d exp 1 1 0", lat, er, nbeats); end
`endif
   endtask

   task automatic test_byte_load();
      bd0 = 32'hDEADBEEF;
      do_req(32'h2001, 32'h0, 2'd0, 1'b0, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
      total++; if (rd !== 32'h000000BE || er !== 1'b0) begin bad++; $display("FAIL ld_byte_u got rd=%h err=%b exp 000000be 0", rd, er); end
      total++; if (lat !== 3) begin bad++; $display("FAIL ld_byte_lat got=%0d exp=3", lat); end
      total++; if (nbeats !== 1 || rec_addr[0] !== 32'h2000 || rec_be[0] !== 4'b0010) begin bad++;
         $display("FAIL ld_byte_beat got beats=%0d addr=%h be=%b exp 1 2000 0010", nbeats, rec_addr[0], rec_be[0]); end
      do_req(32'h2001, 32'h0, 2'd0, 1'b0, 1'b1, lat, rd, er, rdy0, rv0, rdy1);
      total++; if (rd !== 32'hFFFFFFBE) begin bad++; $display("FAIL ld_byte_s got=%h exp=ffffffbe", rd); end
   endtask

   task automatic test_gnt_stall();
      bd0       = 32'h12345678;
      gnt_stall = 5;
      unstable  = 1'b0;
      do_req(32'h3004, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
      gnt_stall = 0;
      total++; if (lat !== 8) begin bad++; $display("FAIL stall_lat got=%0d exp=8", lat); end
      total++; if (unstable !== 1'b0) begin bad++; $display("FAIL stall_stable got=%b exp=0", unstable); end
      total++; if (rd !== 32'h12345678 || rec_addr[0] !== 32'h3004 || rec_be[0] !== 4'hF) begin bad++;
         $display("FAIL stall_data got rd=%h addr=%h be=%b exp 12345678 3004 1111", rd, rec_addr[0], rec_be[0]); end
   endtask

   task automatic test_misaligned_word();
      bd0 = 32'hAABBCCDD;
      bd1 = 32'h11223344;
      do_req(32'h1001, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
`ifdef LSU_MISALIGNED_EN
      total++; if (rd !== 32'h44AABBCC || lat !== 5) begin bad++; $display("FAIL ld_word_split got rd=%h lat=%0d exp 44aabbcc 5", rd, lat); end
      total++; if (rec_be[0] !== 4'b1110 || rec_be[1] !== 4'b0001 || rec_addr[1] !== 32'h1004) begin bad++;
         $display("FAIL ld_word_beats got be0=%b be1=%b a1=%h exp 1110 0001 1004", rec_be[0], rec_be[1], rec_addr[1]); end
`else
      total++; if (lat !== 1 || er !== 1'b1) begin bad++; $display("FAIL ld_word_err got lat=%0d err=%b exp 1 1", lat, er); end
      total++; if (nbeats !== 0 || rd !== 32'h0) begin bad++; $display("FAIL ld_word_nobus got beats=%0d rd=%h exp 0 0", nbeats, rd); end
`endif
   endtask

   task automatic test_double_err();
      do_req(32'h0040, 32'h0, 2'd3, 1'b0, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
      total++; if (lat !== 1 || er !== 1'b1) begin bad++; $display("FAIL dbl_err got lat=%0d err=%b exp 1 1", lat, er); end
      total++; if (nbeats !== 0) begin bad++; $display("FAIL dbl_nobus got=%0d exp=0", nbeats); end
   endtask

   task automatic test_wrap();
      do_req(32'hFFFFFFFF, 32'h0000BEEF, 2'd1, 1'b1, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
`ifdef LSU_MISALIGNED_EN
      total++; if (rec_addr[0] !== 32'hFFFFFFFC || rec_be[0] !== 4'b1000 || rec_wdata[0] !== 32'hEF000000) begin bad++;
         $display("FAIL wrap_b0 got addr=%h be=%b wd=%h exp fffffffc 1000 ef000000", rec_addr[0], rec_be[0], rec_wdata[0]); end
      total++; if (rec_addr[1] !== 32'h0 || rec_be[1] !== 4'b0001 || rec_wdata[1] !== 32'h000000BE || er !== 1'b0) begin bad++;
         $display("FAIL wrap_b1 got addr=%h be=%b wd=%h err=%b exp 0 0001 be 0", rec_addr[1], rec_be[1], rec_wdata[1], er); end
`else
      total++; if (lat !== 1 || er !== 1'b1 || nbeats !== 0) begin bad++;
         $display("FAIL wrap_err got lat=%0d err=%b beats=%0d exp 1 1 0", lat, er, nbeats); end
`endif
   endtask

   task automatic test_back_to_back();
      bd0 = 32'h80000000;
      do_req(32'h2003, 32'h0, 2'd0, 1'b0, 1'b1, lat, rd, er, rdy0, rv0, rdy1);
      total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL b2b_load got=%h exp=ffffff80", rd); end
      do_req(32'h2006, 32'h00001234, 2'd1, 1'b1, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
      total++; if (rdy0 !== 1'b1 || rv0 !== 1'b0) begin bad++; $display("FAIL b2b_accept got ready=%b resp=%b exp 1 0", rdy0, rv0); end
      total++; if (lat !== 3 || rd !== 32'h0 || rec_be[0] !== 4'b1100 || rec_wdata[0] !== 32'h12340000) begin bad++;
         $display("FAIL b2b_store got lat=%0d rd=%h be=%b wd=%h exp 3 0 1100 12340000", lat, rd, rec_be[0], rec_wdata[0]); end
   endtask

   task automatic test_reset_mid();
      int  want;
      bit  reached;
      bit  saw_resp;
      reached  = 1'b0;
      saw_resp = 1'b0;
      bd0 = 32'h01020304;
      bd1 = 32'h05060708;
`ifdef LSU_MISALIGNED_EN
      want = 2;
`else
      want = 1;
`endif
      @(negedge clk_i);
      nbeats       = 0;
      req_valid_i  = 1'b1;
      req_addr_i   = (want == 2) ? 32'h1002 : 32'h1000;
      req_size_i   = 2'd2;
      req_we_i     = 1'b0;
      req_signed_i = 1'b0;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (nbeats == want) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      total++; if (reached !== 1'b1) begin bad++; $display("FAIL rstmid_reach got beats=%0d exp=%0d", nbeats, want); end
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      #1;
      total++; if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0 || resp_valid_o !== 1'b0) begin bad++;
         $display("FAIL rstmid_ctrl got ready=%b req=%b resp=%b exp 1 0 0", req_ready_o, mem_req_o, resp_valid_o); end
      total++; if (mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0) begin bad++;
         $display("FAIL rstmid_bus got addr=%h be=%b wd=%h exp 0 0 0", mem_addr_o, mem_be_o, mem_wdata_o); end
      @(negedge clk_i);
      #2;
      reset_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         if (resp_valid_o !== 1'b0) saw_resp = 1'b1;
      end
      total++; if (saw_resp !== 1'b0 || nbeats !== want) begin bad++;
         $display("FAIL rstmid_quiet got resp=%b beats=%0d exp 0 %0d", saw_resp, nbeats, want); end
      bd0 = 32'h000000FF;
      do_req(32'h2000, 32'h0, 2'd0, 1'b0, 1'b0, lat, rd, er, rdy0, rv0, rdy1);
      total++; if (lat !== 3 || rd !== 32'h000000FF) begin bad++; $display("FAIL rstmid_recover got lat=%0d rd=%h exp 3 000000ff", lat, rd); end
   endtask

   initial begin
      test_reset();
      test_store_split();
      test_signed_half_split();
      test_byte_load();
      test_gnt_stall();
      test_misaligned_word();
      test_double_err();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_split_engine.md
# lsu_split_engine

Parametrised load/store unit sitting between the EX/MEM pipeline stages and the data-memory bus. It accepts one access at a time from the pipeline over a valid/ready handshake and handles byte, half, word and (when DATA_W=64) double accesses. Accesses that cross a bus-word boundary are split into two bus beats by an internal state machine; the block then merges the load data and sign- or zero-extends it. It replaces the fixed 32-bit, pipeline-stalled misaligned scheme with a self-contained handshake engine.

## Interface
- DATA_W, 32, bus/register width; legal values 32 or 64. NB = DATA_W/8; OFF_W = log2(NB).
- ADDR_W, 32, byte-address width.
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous active-low reset.
- req_valid_i / req_ready_o  in/out  1  pipeline request handshake.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data, LSB-justified.
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=double.
- req_we_i  in  1  1=store, 0=load.
- req_signed_i  in  1  sign-extend load result.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  DATA_W  extended load data; 0 for stores.
- resp_err_o  out  1  illegal access; valid with resp_valid_o.
- mem_req_o / mem_gnt_i  out/in  1  bus request/grant.
- mem_addr_o  out  ADDR_W  NB-aligned beat address.
- mem_we_o  out  1  beat is a write.
- mem_be_o  out  NB  byte enables.
- mem_wdata_o  out  DATA_W  lane-aligned write data.
- mem_rvalid_i  in  1  beat completion (loads and stores).
- mem_rdata_i  in  DATA_W  read data, valid with mem_rvalid_i.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready_o=1. On valid&ready, latch address, data, size, we and signed. Compute off = addr[OFF_W-1:0], S = 1<<size, split = (off+S > NB).
- Error cases: size==3 with DATA_W=32, or split with the macro undefined. In these cases go directly to RESP with resp_err_o=1 and issue no bus beat. Otherwise go to REQ0.
- REQ0: mem_req_o=1 with address/be/wdata held stable until mem_gnt_i, then go to WAIT0.
- Beat 0 fields: addr = {addr[ADDR_W-1:OFF_W], 0}; be = ((1<<S)-1)<<off, truncated to NB bits; wdata = wdata<<8·off.
- WAIT0: on mem_rvalid_i, capture rdata0, then go to REQ1 if split, else RESP.
- REQ1/WAIT1: as REQ0/WAIT0, with these beat-1 fields: addr = beat-0 addr + NB; be = ((1<<S)-1) >> (NB−off); wdata = wdata >> 8·(NB−off).
- Load merge: raw = (rdata0 >> 8·off) | (split ? rdata1 << 8·(NB−off) : 0).
- Load result: keep the low S bytes of raw, then extend bit 8·S−1 if signed, else zero-fill.
- RESP: resp_valid_o=1 for exactly one cycle, then return to IDLE. The pipeline must accept it; there is no resp backpressure.
- mem_rvalid_i outside WAIT0/WAIT1 is ignored. mem_gnt_i outside REQ0/REQ1 is ignored.
- Address wrap: beat-1 address wraps modulo 2^ADDR_W without error.

## Timing
- Reset values: state=IDLE; req_ready_o=1; all other outputs 0, including mem_addr_o, mem_be_o, mem_wdata_o and resp_rdata_o.
- Reset asserted mid-operation abandons the access. No response is produced, and the bus owner must discard any in-flight beat.
- Aligned access with immediate gnt and rvalid one cycle after gnt:
  - accept at cycle 0;
  - mem_req_o at cycle 1;
  - rvalid at cycle 2;
  - resp_valid_o at cycle 3.
- Split access takes 2 cycles longer (resp at cycle 5).
- Error response: resp_valid_o at cycle 1.
- req_ready_o=0 in every state except IDLE. A new request can be accepted in the cycle after RESP.
- Every output is registered or a decode of the state register only; no input-to-output combinational path.

## Configuration
- LSU_MISALIGNED_EN defined: split accesses are executed as two beats, as described above.
- LSU_MISALIGNED_EN undefined: REQ1/WAIT1 are not built. Any split access returns resp_err_o=1 with no bus activity.

## Structure
- Package lsu_pkg holds:
  - state enum;
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - function be_mask(size, off, NB).
- Sub-module lsu_align: the combinational shift/merge/extend network, parametrised by DATA_W. It produces beat-0/1 be and wdata, and the final load result.

## Test plan
- DATA_W=32, store word 0xA1B2C3D4 at 0x1002:
  - beat 0: addr 0x1000, be 4'b1100, wdata 0xC3D40000;
  - beat 1: addr 0x1004, be 4'b0011, wdata 0x0000A1B2;
  - then resp, err=0.
- Signed half load at 0x1003, with rdata0=0x11223344 and rdata1=0x556677F8 -> resp_rdata_o=0xFFFFF811.
- Byte load at 0x2001, rdata=0xDEADBEEF -> unsigned 0x000000BE, signed 0xFFFFFFBE; single beat with be 4'b0010.
- mem_gnt_i held low for 5 cycles in REQ0 -> mem_req_o, mem_addr_o and mem_be_o stay stable; resp arrives 5 cycles later than the no-stall case.
- Macro undefined, word load at 0x1001 -> no mem_req_o, resp_valid_o with resp_err_o=1 at cycle 1.
- reset_i pulsed low while in WAIT1 -> all outputs 0 and state IDLE immediately; no resp_valid_o afterwards.
